// File: rtl/uart_pkg.sv
// Shared UART definitions: receive capture FSM states, error-bit indices and
// the stored frame layout.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_RECV   = 2'd1,
    RX_COMMIT = 2'd2,
    RX_HOLD   = 2'd3
  } rx_ctrl_state_t;

  localparam int ERR_PARITY = 0;
  localparam int ERR_START  = 1;
  localparam int ERR_STOP   = 2;

  localparam int FRAME_DATA_W = 8;
  localparam int FRAME_ERR_W  = 3;
  localparam int FRAME_W      = FRAME_DATA_W + FRAME_ERR_W;

  typedef struct packed {
    logic [FRAME_ERR_W-1:0]  error;
    logic [FRAME_DATA_W-1:0] data;
  } rx_frame_t;

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock FIFO with registered pop output. A separate occupancy count keeps
// full/empty unambiguous while the pointers wrap freely.
module rx_sync_fifo #(
  parameter int DATA_W = 11,
  parameter int DEPTH  = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              rd_acc;
  logic              wr_acc;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  // A pop in the same cycle frees the slot, so a write at full still lands.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_acc;
      count    <= count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        rd_data <= mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: turns each receiver rx_done rise into one FIFO write,
// buffers frames with their error bits and tracks overrun / error statistics.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH           = 8,
  parameter bit DROP_ERR_FRAMES = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [7:0]               rx_data,
  input  logic [2:0]               rx_error,
  input  logic                     rx_active,
  input  logic                     rx_done,
  input  logic                     rd_en,
  input  logic                     clr_overrun,
  output logic [7:0]               data_out,
  output logic [2:0]               error_out,
  output logic                     data_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  output logic [7:0]               err_count,
  output logic                     rx_busy
);

  rx_ctrl_state_t state;
  rx_ctrl_state_t state_nxt;
  logic           done_prev_p0;
  logic           done_rise;
  logic           capture;
  rx_frame_t      frame_p0;
  rx_frame_t      frame_rd;
  logic           commit;
  logic           frame_err;
  logic           wr_en;
  logic           rd_acc;
  logic           lose_frame;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign done_rise = rx_done && !done_prev_p0;
  assign capture   = done_rise && (state == RX_IDLE || state == RX_RECV);
  assign commit    = (state == RX_COMMIT);
  assign frame_err = |frame_p0.error;
  assign wr_en     = commit && !(DROP_ERR_FRAMES && frame_err);
  assign rd_acc    = rd_en && !empty;
  assign lose_frame = wr_en && full && !rd_acc;
  assign rx_busy   = (state == RX_RECV);

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:   if (done_rise) state_nxt = RX_COMMIT;
                 else if (rx_active) state_nxt = RX_RECV;
      RX_RECV:   if (done_rise) state_nxt = RX_COMMIT;
      RX_COMMIT: state_nxt = RX_HOLD;
      RX_HOLD:   if (!rx_done) state_nxt = RX_IDLE;
      default:   state_nxt = RX_IDLE;
    endcase
  end

  // Edge detector resets high so a level already present at release is ignored.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RX_IDLE;
      done_prev_p0 <= 1'b1;
      overrun      <= 1'b0;
      err_count    <= '0;
    end else begin
      state        <= state_nxt;
      done_prev_p0 <= rx_done;
      if (lose_frame) overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
      if (commit && frame_err) err_count <= sat_inc8(err_count);
    end
  end

  always_ff @(posedge clock) begin
    if (capture) frame_p0 <= '{error: rx_error, data: rx_data};
  end

  rx_sync_fifo #(
    .DATA_W (FRAME_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_data  (frame_p0),
    .rd_en    (rd_en),
    .rd_data  (frame_rd),
    .rd_valid (data_valid),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign data_out  = frame_rd.data;
  assign error_out = frame_rd.error;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized bench for uart_rx_ctrl: two instances (keep / drop error frames)
// share stimulus and are compared against a frame-level queue model.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic [2:0] rx_error = '0;
  logic       rx_active = 1'b0;
  logic       rx_done = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_overrun = 1'b0;

  logic [7:0]    data_out_w  [2];
  logic [2:0]    error_out_w [2];
  logic          data_valid_w[2];
  logic          empty_w     [2];
  logic          full_w      [2];
  logic [CW-1:0] count_w     [2];
  logic          overrun_w   [2];
  logic [7:0]    err_count_w [2];
  logic          rx_busy_w   [2];

  uart_rx_ctrl #(.DEPTH(DEPTH), .DROP_ERR_FRAMES(1'b0)) dut0 (
    .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_error(rx_error),
    .rx_active(rx_active), .rx_done(rx_done), .rd_en(rd_en), .clr_overrun(clr_overrun),
    .data_out(data_out_w[0]), .error_out(error_out_w[0]), .data_valid(data_valid_w[0]),
    .empty(empty_w[0]), .full(full_w[0]), .count(count_w[0]), .overrun(overrun_w[0]),
    .err_count(err_count_w[0]), .rx_busy(rx_busy_w[0]));

  uart_rx_ctrl #(.DEPTH(DEPTH), .DROP_ERR_FRAMES(1'b1)) dut1 (
    .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_error(rx_error),
    .rx_active(rx_active), .rx_done(rx_done), .rd_en(rd_en), .clr_overrun(clr_overrun),
    .data_out(data_out_w[1]), .error_out(error_out_w[1]), .data_valid(data_valid_w[1]),
    .empty(empty_w[1]), .full(full_w[1]), .count(count_w[1]), .overrun(overrun_w[1]),
    .err_count(err_count_w[1]), .rx_busy(rx_busy_w[1]));

  always #5 clock = ~clock;

  // Reference model: per instance a circular list of {error,data} frames.
  logic [10:0] mbuf [2][DEPTH];
  int          mhead [2];
  int          msize [2];
  int          merrc [2];
  bit          movr  [2];
  bit          exp_dv[2];
  logic [10:0] exp_out[2];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mhead[i] = 0; msize[i] = 0; merrc[i] = 0;
      movr[i] = 0; exp_dv[i] = 0; exp_out[i] = '0;
    end
  endtask

  // One clock of consumer/producer activity: a read (if any) frees a slot first.
  task automatic model_step(input bit wr, input logic [7:0] d, input logic [2:0] e,
                            input bit rd, input bit clr);
    for (int i = 0; i < 2; i++) begin
      exp_dv[i] = 0;
      if (clr) movr[i] = 0;
      if (rd && msize[i] > 0) begin
        exp_out[i] = mbuf[i][mhead[i]];
        mhead[i] = (mhead[i] + 1) % DEPTH;
        msize[i]--;
        exp_dv[i] = 1;
      end
      if (wr) begin
        if (e != 0 && merrc[i] < 255) merrc[i]++;
        if (!(i == 1 && e != 0)) begin
          if (msize[i] < DEPTH) begin
            mbuf[i][(mhead[i] + msize[i]) % DEPTH] = {e, d};
            msize[i]++;
          end else begin
            movr[i] = 1;
          end
        end
      end
    end
  endtask

  task automatic check_state();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("count[%0d]", i), int'(count_w[i]), msize[i]);
      check_eq($sformatf("empty[%0d]", i), int'(empty_w[i]), (msize[i] == 0) ? 1 : 0);
      check_eq($sformatf("full[%0d]", i), int'(full_w[i]), (msize[i] == DEPTH) ? 1 : 0);
      check_eq($sformatf("overrun[%0d]", i), int'(overrun_w[i]), int'(movr[i]));
      check_eq($sformatf("err_count[%0d]", i), int'(err_count_w[i]), merrc[i]);
      check_eq($sformatf("data_out[%0d]", i), int'(data_out_w[i]), int'(exp_out[i][7:0]));
      check_eq($sformatf("error_out[%0d]", i), int'(error_out_w[i]), int'(exp_out[i][10:8]));
      check_eq($sformatf("data_valid[%0d]", i), int'(data_valid_w[i]), int'(exp_dv[i]));
    end
  endtask

  // Frame: active for two cycles, then rx_done held for 'hold' cycles.
  task automatic send_frame(input logic [7:0] d, input logic [2:0] e, input int hold,
                            input bit rd_c, input bit clr_c);
    rx_data = d; rx_error = e; rx_active = 1'b1;
    tick(); tick();
    for (int i = 0; i < 2; i++) check_eq($sformatf("rx_busy[%0d]", i), int'(rx_busy_w[i]), 1);
    rx_done = 1'b1; rx_active = 1'b0;
    tick();
    rd_en = rd_c; clr_overrun = clr_c;
    tick();
    model_step(1'b1, d, e, rd_c, clr_c);
    rd_en = 1'b0; clr_overrun = 1'b0;
    check_state();
    repeat (hold - 2) tick();
    rx_done = 1'b0;
    rx_data = $urandom; rx_error = 3'($urandom);
    tick(); tick();
    model_step(1'b0, '0, '0, 1'b0, 1'b0);
    check_state();
  endtask

  task automatic do_reads(input int n);
    rd_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick();
      model_step(1'b0, '0, '0, 1'b1, 1'b0);
      check_state();
    end
    rd_en = 1'b0;
    tick();
    model_step(1'b0, '0, '0, 1'b0, 1'b0);
    check_state();
  endtask

  task automatic do_clr();
    clr_overrun = 1'b1;
    tick();
    model_step(1'b0, '0, '0, 1'b0, 1'b1);
    clr_overrun = 1'b0;
    check_state();
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    check_state();
    for (int i = 0; i < 2; i++) check_eq($sformatf("rx_busy_rst[%0d]", i), int'(rx_busy_w[i]), 0);
    reset_n = 1'b1;
    tick(); tick();

    // Read on empty is ignored.
    do_reads(1);

    // Single frame, long rx_done level.
    send_frame(8'hA5, 3'b000, 10, 1'b0, 1'b0);
    do_reads(1);

    // Fill and overrun.
    for (int i = 0; i < 9; i++) send_frame(8'(i), 3'b000, 2, 1'b0, 1'b0);
    do_reads(8);
    do_clr();

    // Error frame: kept by instance 0, discarded by instance 1.
    send_frame(8'h3C, 3'b100, 3, 1'b0, 1'b0);
    do_reads(1);

    // Full with simultaneous read and write.
    for (int i = 0; i < 8; i++) send_frame(8'($urandom), 3'b000, 2, 1'b0, 1'b0);
    send_frame(8'hC3, 3'b000, 2, 1'b1, 1'b0);
    do_reads(9);

    // Randomized mix of frames, reads and clears.
    for (int it = 0; it < 80; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        logic [2:0] e;
        e = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        send_frame(8'($urandom), e, $urandom_range(2, 6),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end else if (r <= 8) begin
        do_reads($urandom_range(1, 3));
      end else begin
        do_clr();
      end
    end

    // Reset in RECV with three entries stored and rx_done high across release.
    do_reads(msize[0] + 1);
    for (int i = 0; i < 3; i++) send_frame(8'(8'h10 + i), 3'b000, 2, 1'b0, 1'b0);
    rx_active = 1'b1;
    tick(); tick();
    for (int i = 0; i < 2; i++) check_eq($sformatf("rx_busy_pre[%0d]", i), int'(rx_busy_w[i]), 1);
    reset_n = 1'b0;
    rx_active = 1'b0; rx_done = 1'b1; rx_data = 8'h77; rx_error = 3'b000;
    #1;
    model_reset();
    check_state();
    for (int i = 0; i < 2; i++) check_eq($sformatf("rx_busy_mid[%0d]", i), int'(rx_busy_w[i]), 0);
    tick(); tick();
    reset_n = 1'b1;
    repeat (4) tick();
    model_step(1'b0, '0, '0, 1'b0, 1'b0);
    check_state();
    rx_done = 1'b0;
    tick(); tick();
    send_frame(8'h5A, 3'b000, 3, 1'b0, 1'b0);
    do_reads(1);

    // err_count saturation.
    for (int i = 0; i < 260; i++)
      send_frame(8'($urandom), 3'($urandom_range(1, 7)), 2, 1'b0, 1'b0);
    do_reads(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller of the UART path. It converts the receiver unit's `done_flag` and `data_out`/`error_flag` outputs into exactly one FIFO write per frame. It buffers frames with their error bits and serves them to the consumer (CPU/bus side) through a registered read handshake, with overrun and error accounting. It is the read-direction counterpart of the transmit-side FIFO/read-enable controller.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `DROP_ERR_FRAMES`, 0: 1 = frames with any error bit set are discarded and not stored.

Ports:
- `clock` in 1: system clock; single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: receiver parallel data; valid while `rx_done` is high.
- `rx_error` in 3: receiver error flags: [0] parity, [1] start, [2] stop.
- `rx_active` in 1: receiver frame in progress.
- `rx_done` in 1: receiver frame complete; a level that may stay high for many cycles.
- `rd_en` in 1: consumer read request.
- `clr_overrun` in 1: clears `overrun`.
- `data_out` out 8: read data, registered.
- `error_out` out 3: error bits stored with `data_out`.
- `data_valid` out 1: 1-cycle pulse when `data_out`/`error_out` are updated.
- `empty` out 1: FIFO empty.
- `full` out 1: FIFO full.
- `count` out $clog2(DEPTH)+1: stored entry count.
- `overrun` out 1: sticky; a frame was lost because the FIFO was full.
- `err_count` out 8: saturating count of frames with any error bit set.
- `rx_busy` out 1: controller is in RECV state.

## Operation
- Capture FSM states: IDLE, RECV, COMMIT, HOLD.
  - IDLE → RECV when `rx_active`=1.
  - IDLE or RECV → COMMIT on a rising edge of `rx_done` (current sample 1, previous sample 0).
  - RECV stays in RECV otherwise.
  - COMMIT → HOLD unconditionally.
  - HOLD → IDLE when `rx_done`=0.
- `rx_data`/`rx_error` are registered at the edge that detects the `rx_done` rise. The write uses these registered values.
- COMMIT write decision:
  - If `DROP_ERR_FRAMES`=1 and `|rx_error`, nothing is written.
  - Else if not full, or a read is accepted in the same cycle, {error, data} is written.
  - Else the frame is dropped and `overrun` is set.
- `err_count` increments in COMMIT whenever `|rx_error`, whether the frame is stored, dropped or discarded. It saturates at 255.
- Read: `rd_en`=1 with `count`>0 pops the head entry into `data_out`/`error_out` and pulses `data_valid`. `rd_en` on empty is ignored: no pulse, outputs hold.
- Simultaneous write and read at full: both succeed and `count` is unchanged. Simultaneous write and read at empty: the read is ignored and the write proceeds.
- `clr_overrun` clears `overrun`. If an overrun occurs in the same cycle, set wins.
- Pointers wrap modulo DEPTH. `count` is held separately, so full and empty are unambiguous.

## Timing
- Reset values:
  - `data_out`=0, `error_out`=0, `data_valid`=0.
  - `empty`=1, `full`=0, `count`=0.
  - `overrun`=0, `err_count`=0, `rx_busy`=0.
  - FSM in IDLE.
  - The `rx_done` edge-detect register resets to 1.
- Because the edge-detect register resets to 1, an `rx_done` already high at reset release is not committed. Reset mid-frame discards that frame.
- Write latency: `rx_done` rise sampled at edge k, then COMMIT during cycle k→k+1, then the entry is stored at edge k+1. `empty` falls and `count` increments after edge k+1.
- Read latency: `rd_en` sampled at edge j, then `data_out`/`error_out`/`data_valid` are valid in cycle j→j+1. `count` decrements after edge j.
- Back-to-back `rd_en` delivers one entry per cycle.
- Capture rate: at most one frame per `rx_done` high period. A minimum of 3 cycles separates commits.

## Structure
- Shared `uart_pkg`:
  - capture FSM enum (`rx_ctrl_state_t`)
  - error-bit index constants `ERR_PARITY`=0, `ERR_START`=1, `ERR_STOP`=2
  - frame-entry struct {error[2:0], data[7:0]}
- Sub-module `rx_sync_fifo`: single-clock FIFO with registered pop output, parameterised by width/depth, with count/full/empty. The capture FSM and counters live in `uart_rx_ctrl`.

## Test plan
- Single frame: `rx_data`=0xA5, `rx_error`=0, `rx_done` held high for 10 cycles. Required: exactly one write, `count`=1. Then `rd_en` → `data_out`=0xA5, `error_out`=0, one `data_valid` pulse, `empty`=1.
- Fill and overrun with DEPTH=8: commit 0x00..0x08. Required: after 8 frames `full`=1; the 9th sets `overrun`=1 with `count`=8. Read-out returns 0x00..0x07 in order. Then `clr_overrun` → `overrun`=0.
- Error handling: frame 0x3C with `rx_error`=3'b100. With `DROP_ERR_FRAMES`=0, it is stored with `error_out`=3'b100 and `err_count`=1. With `DROP_ERR_FRAMES`=1, `count` stays 0 and `err_count`=1.
- Full with simultaneous read and write: at `count`=8, the COMMIT cycle coincides with `rd_en`. Required: oldest entry output, new frame stored, `count`=8, `overrun`=0.
- Reset mid-operation: assert `reset_n`=0 during RECV with `count`=3 and `rx_done` held high across release. Required: all outputs at reset values, no commit after release, and the next clean `rx_done` rise stores normally.
- Read on empty: `rd_en` pulsed with `count`=0. Required: no `data_valid`, `data_out` unchanged, `count`=0.
